// File: rtl/scan_pkg.sv
// Shared types and sizing helpers for the segmented mux-scan register.
package scan_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD    = 2'd0,
    MODE_CAPTURE = 2'd1,
    MODE_SHIFT   = 2'd2
  } scan_mode_e;

  function automatic int seg_len(input int width, input int chains);
    return width / chains;
  endfunction

  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

  function automatic bit split_ok(input int width, input int chains);
    return (chains > 0) && (width > 0) && ((width % chains) == 0);
  endfunction

endpackage

// File: rtl/scan_seg.sv
// One LEN-bit scan chain segment: shift toward the MSB, parallel capture, or hold.
module scan_seg
  import scan_pkg::*;
#(
  parameter int LEN = 4
) (
  input  logic             CLK,
  input  logic             R,
  input  scan_mode_e       i_mode,
  input  logic             i_si,
  input  logic [LEN-1:0]   i_d,
  output logic [LEN-1:0]   o_seg,
  output logic             o_so
);

  logic [LEN-1:0] r_seg;
  logic [LEN-1:0] w_shift;

  genvar gi;
  generate
    for (gi = 0; gi < LEN; gi++) begin : g_shift
      if (gi == 0) begin : g_head
        assign w_shift[gi] = i_si;
      end else begin : g_body
        assign w_shift[gi] = r_seg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!R) begin
      r_seg <= '0;
    end else begin
      case (i_mode)
        MODE_SHIFT:   r_seg <= w_shift;
        MODE_CAPTURE: r_seg <= i_d;
        default:      r_seg <= r_seg;
      endcase
    end
  end

  assign o_seg = r_seg;
  // The MSB is the bit that leaves on the next shift.
  assign o_so  = r_seg[LEN-1];

endmodule

// File: rtl/scan_chain_reg.sv
// WIDTH-bit mux-scan register split into CHAINS chains, with update shadow and
// shift counter. Define SCAN_BYPASS_EN to add a per-chain 1-bit bypass path (BYP).
module scan_chain_reg
  import scan_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int CHAINS = 1,
  localparam int LEN    = seg_len(WIDTH, CHAINS),
  localparam int CNT_W  = cnt_width(LEN)
) (
  input  logic              CLK,
  input  logic              R,
  input  logic              SE,
  input  logic              CE,
  input  logic              UPD,
`ifdef SCAN_BYPASS_EN
  input  logic              BYP,
`endif
  input  logic [WIDTH-1:0]  D,
  input  logic [CHAINS-1:0] SI,
  output logic [CHAINS-1:0] SO,
  output logic [WIDTH-1:0]  Q,
  output logic [WIDTH-1:0]  CHAIN,
  output logic [CNT_W-1:0]  SHIFT_CNT,
  output logic              SHIFT_DONE
);

  localparam logic [CNT_W-1:0] LEN_CNT = CNT_W'(LEN);

  generate
    if (!split_ok(WIDTH, CHAINS)) begin : g_bad_split
      $error("scan_chain_reg: WIDTH must be a positive multiple of CHAINS");
    end
  endgenerate

  logic              w_byp_act;
  scan_mode_e        w_mode;
  logic [WIDTH-1:0]  w_chain;
  logic [CHAINS-1:0] w_seg_so;
  logic [WIDTH-1:0]  r_q;
  logic [CNT_W-1:0]  r_cnt;

`ifdef SCAN_BYPASS_EN
  logic [CHAINS-1:0] r_byp;

  assign w_byp_act = SE & BYP;

  always_ff @(posedge CLK) begin
    if (!R) begin
      r_byp <= '0;
    end else if (w_byp_act) begin
      r_byp <= SI;
    end
  end

  assign SO = BYP ? r_byp : w_seg_so;
`else
  assign w_byp_act = 1'b0;
  assign SO        = w_seg_so;
`endif

  // Shift beats capture; an active bypass freezes the main chain.
  always_comb begin
    w_mode = MODE_HOLD;
    if (SE) begin
      w_mode = w_byp_act ? MODE_HOLD : MODE_SHIFT;
    end else if (CE) begin
      w_mode = MODE_CAPTURE;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHAINS; gi++) begin : g_chain
      scan_seg #(
        .LEN (LEN)
      ) u_seg (
        .CLK    (CLK),
        .R      (R),
        .i_mode (w_mode),
        .i_si   (SI[gi]),
        .i_d    (D[gi*LEN +: LEN]),
        .o_seg  (w_chain[gi*LEN +: LEN]),
        .o_so   (w_seg_so[gi])
      );
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!R) begin
      r_cnt <= '0;
    end else begin
      case (w_mode)
        MODE_SHIFT: begin
          if (r_cnt != LEN_CNT) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        MODE_CAPTURE: r_cnt <= '0;
        default:      r_cnt <= r_cnt;
      endcase
    end
  end

  // Shadow takes the pre-edge chain, so it can coincide with shift or capture.
  always_ff @(posedge CLK) begin
    if (!R) begin
      r_q <= '0;
    end else if (UPD) begin
      r_q <= w_chain;
    end
  end

  assign Q          = r_q;
  assign CHAIN      = w_chain;
  assign SHIFT_CNT  = r_cnt;
  assign SHIFT_DONE = (r_cnt == LEN_CNT);

endmodule

// File: tb/tb_scan_chain_reg.sv
// Directed self-checking bench for scan_chain_reg (WIDTH=8, CHAINS=2, LEN=4).
module tb_scan_chain_reg;

  localparam int WIDTH  = 8;
  localparam int CHAINS = 2;
  localparam int CNT_W  = 3;

  logic              CLK = 1'b0;
  logic              R   = 1'b0;
  logic              SE  = 1'b0;
  logic              CE  = 1'b0;
  logic              UPD = 1'b0;
`ifdef SCAN_BYPASS_EN
  logic              BYP = 1'b0;
`endif
  logic [WIDTH-1:0]  D   = '0;
  logic [CHAINS-1:0] SI  = '0;
  logic [CHAINS-1:0] SO;
  logic [WIDTH-1:0]  Q;
  logic [WIDTH-1:0]  CHAIN;
  logic [CNT_W-1:0]  SHIFT_CNT;
  logic              SHIFT_DONE;

  int n_checks = 0;
  int n_fail   = 0;

  scan_chain_reg #(
    .WIDTH  (WIDTH),
    .CHAINS (CHAINS)
  ) dut (
    .CLK        (CLK),
    .R          (R),
    .SE         (SE),
    .CE         (CE),
    .UPD        (UPD),
`ifdef SCAN_BYPASS_EN
    .BYP        (BYP),
`endif
    .D          (D),
    .SI         (SI),
    .SO         (SO),
    .Q          (Q),
    .CHAIN      (CHAIN),
    .SHIFT_CNT  (SHIFT_CNT),
    .SHIFT_DONE (SHIFT_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected SO before each shift of 8'hA5: {chain1 MSB, chain0 MSB}
  logic [1:0] so_exp [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

  initial begin
    // Reset with capture requested: reset must win
    R = 1'b0; D = 8'hFF; CE = 1'b1;
    tick();
    check_val("rst_chain", 32'(CHAIN), 32'h00);
    check_val("rst_q",     32'(Q), 32'h00);
    check_val("rst_cnt",   32'(SHIFT_CNT), 32'd0);
    check_val("rst_so",    32'(SO), 32'b00);
    check_val("rst_done",  32'(SHIFT_DONE), 32'd0);

    // Capture then update
    R = 1'b1; SE = 1'b0; CE = 1'b1; D = 8'hA5;
    tick();
    check_val("cap_chain", 32'(CHAIN), 32'hA5);
    check_val("cap_q_pre", 32'(Q), 32'h00);
    check_val("cap_so",    32'(SO), 32'b10);
    CE = 1'b0; UPD = 1'b1;
    tick();
    check_val("upd_q", 32'(Q), 32'hA5);
    UPD = 1'b0;

    // Shift-out of 8'hA5
    SE = 1'b1; SI = 2'b00;
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("shift_so%0d", k), 32'(SO), 32'(so_exp[k]));
      check_val($sformatf("shift_done_pre%0d", k), 32'(SHIFT_DONE), 32'd0);
      tick();
      check_val($sformatf("shift_cnt%0d", k), 32'(SHIFT_CNT), 32'(k + 1));
      check_val($sformatf("shift_q%0d", k), 32'(Q), 32'hA5);
    end
    check_val("shift_chain", 32'(CHAIN), 32'h00);
    check_val("shift_done",  32'(SHIFT_DONE), 32'd1);
    tick();
    check_val("sat_cnt",  32'(SHIFT_CNT), 32'd4);
    check_val("sat_done", 32'(SHIFT_DONE), 32'd1);

    // Capture clears a saturated counter
    SE = 1'b0; CE = 1'b1; D = 8'h3C;
    tick();
    check_val("cap2_chain", 32'(CHAIN), 32'h3C);
    check_val("cap2_cnt",   32'(SHIFT_CNT), 32'd0);
    check_val("cap2_done",  32'(SHIFT_DONE), 32'd0);

    // SE and CE together with UPD: shift wins, Q takes pre-shift chain
    SE = 1'b1; CE = 1'b1; D = 8'hFF; SI = 2'b11; UPD = 1'b1;
    tick();
    check_val("prio_chain", 32'(CHAIN), 32'h79);
    check_val("prio_q",     32'(Q), 32'h3C);
    check_val("prio_cnt",   32'(SHIFT_CNT), 32'd1);

    // Hold
    SE = 1'b0; CE = 1'b0; UPD = 1'b0; D = 8'h00;
    tick();
    check_val("hold_chain", 32'(CHAIN), 32'h79);
    check_val("hold_cnt",   32'(SHIFT_CNT), 32'd1);
    check_val("hold_q",     32'(Q), 32'h3C);

    // Reset mid-shift
    SE = 1'b1; SI = 2'b01;
    tick();
    tick();
    check_val("mid_chain", 32'(CHAIN), 32'hC7);
    check_val("mid_cnt",   32'(SHIFT_CNT), 32'd3);
    R = 1'b0;
    tick();
    check_val("midrst_chain", 32'(CHAIN), 32'h00);
    check_val("midrst_cnt",   32'(SHIFT_CNT), 32'd0);
    check_val("midrst_q",     32'(Q), 32'h00);
    R = 1'b1; SI = 2'b11;
    tick();
    check_val("resume_cnt",   32'(SHIFT_CNT), 32'd1);
    check_val("resume_chain", 32'(CHAIN), 32'h11);

`ifdef SCAN_BYPASS_EN
    BYP = 1'b1; SE = 1'b1; SI = 2'b10;
    tick();
    check_val("byp_so",    32'(SO), 32'b10);
    check_val("byp_chain", 32'(CHAIN), 32'h11);
    check_val("byp_cnt",   32'(SHIFT_CNT), 32'd1);
    BYP = 1'b0; SE = 1'b0;
    tick();
    check_val("byp_off_so", 32'(SO), 32'b00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
